// File: rtl/seg7_capture.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: waits for each digit's
// dwell to settle, decodes the glyph back to a nibble and publishes complete 16-bit frames.
module seg7_capture #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  an,
  input  logic [6:0]  a_to_g,
  output logic [15:0] digits,
  output logic        valid,
  output logic        seg_err,
  output logic        an_err,
  output logic        stale
);

  localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SettleCnt  = 8'(SETTLE);
  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  logic [3:0]    an_s1, an_s2, an_p;
  logic [6:0]    seg_s1, seg_s2, seg_p;
  logic [7:0]    stab_q, stab_d;
  logic          fired_q, fired_d;
  logic [3:0]    seen_q, seen_d;
  logic          err_q, err_d;
  logic [15:0]   slots_q, slots_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          changed, settle, one_low, blank, capture, publish, expire, bad;
  logic [1:0]    idx;
  logic [3:0]    nib;

  // an_p/seg_p hold the synchronized bus one cycle late, for change detection.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an_s1  <= 4'b1111;
      an_s2  <= 4'b1111;
      an_p   <= 4'b1111;
      seg_s1 <= 7'b1111111;
      seg_s2 <= 7'b1111111;
      seg_p  <= 7'b1111111;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= a_to_g;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  always_comb begin
    bad = 1'b0;
    case (seg_p)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default: begin
        nib = 4'h0;
        bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    one_low = 1'b1;
    idx     = 2'd0;
    case (an_p)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_low = 1'b0;
    endcase

    changed = (an_s2 != an_p) || (seg_s2 != seg_p);
    // fired_q limits each stable window to a single settle event.
    settle  = (stab_q == SettleCnt) && !fired_q;
    blank   = (an_p == 4'b1111);
    capture = settle && one_low;
    publish = (seen_q == 4'b1111);
    expire  = !capture && (tmo_q != TimeoutCnt) && ((tmo_q + 1'b1) == TimeoutCnt);

    stab_d  = stab_q;
    fired_d = fired_q;
    if (changed) begin
      stab_d  = 8'd0;
      fired_d = 1'b0;
    end else begin
      if (stab_q != SettleCnt) stab_d = stab_q + 8'd1;
      if (settle) fired_d = 1'b1;
    end

    tmo_d = tmo_q;
    if (capture) tmo_d = '0;
    else if (tmo_q != TimeoutCnt) tmo_d = tmo_q + 1'b1;

    seen_d  = seen_q;
    err_d   = err_q;
    slots_d = slots_q;
    if (publish || expire) begin
      seen_d = 4'b0000;
      err_d  = 1'b0;
    end
    if (capture) begin
      seen_d[idx]                  = 1'b1;
      err_d                        = err_d | bad;
      slots_d[{idx, 2'b00} +: 4]   = nib;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stab_q  <= 8'd0;
      fired_q <= 1'b0;
      tmo_q   <= '0;
      seen_q  <= 4'b0000;
      err_q   <= 1'b0;
      slots_q <= 16'h0000;
      digits  <= 16'h0000;
      valid   <= 1'b0;
      seg_err <= 1'b0;
      an_err  <= 1'b0;
      stale   <= 1'b1;
    end else begin
      stab_q  <= stab_d;
      fired_q <= fired_d;
      tmo_q   <= tmo_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      slots_q <= slots_d;
      valid   <= publish;
      an_err  <= settle && !blank && !one_low;
      if (publish) begin
        digits  <= slots_q;
        seg_err <= err_q;
        stale   <= 1'b0;
      end else if (expire) begin
        stale   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed latency/boundary steps, then randomized frames checked
// against a frame-level reference model.
module tb_seg7_capture;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [15:0] digits;
  logic        valid, seg_err, an_err, stale;

  seg7_capture #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .an      (an),
    .a_to_g  (a_to_g),
    .digits  (digits),
    .valid   (valid),
    .seg_err (seg_err),
    .an_err  (an_err),
    .stale   (stale)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Monitor: counts pulses and, while the model is on, scores each published frame.
  int          n_valid = 0;
  int          n_anerr = 0;
  logic        valid_prev = 1'b0;
  bit          model_on = 1'b0;
  logic [16:0] exp_q [$];
  logic [16:0] exp_f;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      chk("valid_back_to_back", {31'd0, valid_prev}, 32'd0);
      if (model_on) begin
        chk("frame_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          exp_f = exp_q.pop_front();
          chk("frame_digits", {16'd0, digits}, {16'd0, exp_f[15:0]});
          chk("frame_seg_err", {31'd0, seg_err}, {31'd0, exp_f[16]});
        end
      end
    end
    if (an_err) n_anerr++;
    valid_prev = valid;
  end

  // Reference model: a window held len cycles is sampled once it survives the 2-flop sync
  // plus SETTLE stable compares; windows of SETTLE+2 or more are always sampled.
  logic [3:0] m_slot [4];
  logic [3:0] m_seen;
  logic       m_err;
  int         m_frames, m_anerr;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
    m_seen = 4'b0000;
    m_err  = 1'b0;
  endtask

  task automatic model_window(input logic [3:0] a, input logic [6:0] s, input int len);
    int   zeros;
    int   k;
    logic [3:0] n;
    logic b;
    if (len >= int'(SETTLE) + 2) begin
      zeros = 4 - $countones(a);
      if (zeros == 1) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) k = i;
        n = 4'h0;
        b = 1'b1;
        for (int i = 0; i < 16; i++) if (glyph[i] == s) begin n = 4'(i); b = 1'b0; end
        m_slot[k] = n;
        m_seen[k] = 1'b1;
        m_err     = m_err | b;
        if (m_seen == 4'b1111) begin
          exp_q.push_back({m_err, m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
          m_frames++;
          m_seen = 4'b0000;
          m_err  = 1'b0;
        end
      end else if (zeros >= 2) begin
        m_anerr++;
      end
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an     = a;
    a_to_g = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int k, input int v, input int n);
    logic [3:0] a;
    a    = 4'b1111;
    a[k] = 1'b0;
    hold(a, glyph[v], n);
  endtask

  task automatic rand_window(input logic [3:0] a, input logic [6:0] s, input int n);
    model_window(a, s, n);
    hold(a, s, n);
  endtask

  task automatic do_reset();
    clr    = 1'b0;
    an     = 4'b1111;
    a_to_g = 7'b1111111;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int         v0, a0;
  logic [3:0] ra, rm;
  logic [6:0] rs;

  initial begin
    clr    = 1'b0;
    an     = 4'b1111;
    a_to_g = 7'b1111111;
    repeat (2) @(negedge clk);
    chk("rst_digits", {16'd0, digits}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_seg_err", {31'd0, seg_err}, 32'd0);
    chk("rst_an_err", {31'd0, an_err}, 32'd0);
    chk("rst_stale", {31'd0, stale}, 32'd1);
    clr = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid_count", n_valid, 0);

    // Frame 3,7,A,0; valid lands at edge SETTLE+4 of the last digit.
    v0 = n_valid;
    dig(0, 3, 20); dig(1, 7, 20); dig(2, 10, 20);
    an = 4'b0111; a_to_g = glyph[0];
    repeat (8) @(negedge clk);
    chk("valid_edge7", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("valid_edge8", {31'd0, valid}, 32'd1);
    @(negedge clk);
    chk("valid_edge9", {31'd0, valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("f1_count", n_valid - v0, 1);
    chk("f1_digits", {16'd0, digits}, 32'h0A73);
    chk("f1_seg_err", {31'd0, seg_err}, 32'd0);
    chk("f1_stale", {31'd0, stale}, 32'd0);
    hold(4'b1111, 7'b1111111, 5);

    // Short glitch is never sampled; digit 0 held exactly 6 cycles completes the frame.
    v0 = n_valid;
    dig(1, 5, 10);
    hold(4'b1101, glyph[8], 3);
    hold(4'b1111, 7'b1111111, 5);
    dig(2, 12, 20); dig(3, 14, 20);
    dig(0, 1, 6);
    an = 4'b1111; a_to_g = 7'b1111111;
    repeat (2) @(negedge clk);
    chk("short_valid_edge7", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("short_valid_edge8", {31'd0, valid}, 32'd1);
    repeat (10) @(negedge clk);
    chk("f2_count", n_valid - v0, 1);
    chk("f2_digits", {16'd0, digits}, 32'hEC51);

    // Undecodable glyph in digit 2, then a clean frame.
    v0 = n_valid;
    dig(0, 1, 20); dig(1, 2, 20);
    hold(4'b1011, 7'b1111110, 20);
    dig(3, 4, 20);
    hold(4'b1111, 7'b1111111, 5);
    chk("f3_digits", {16'd0, digits}, 32'h4021);
    chk("f3_seg_err", {31'd0, seg_err}, 32'd1);
    dig(0, 9, 20); dig(1, 8, 20); dig(2, 7, 20); dig(3, 6, 20);
    hold(4'b1111, 7'b1111111, 5);
    chk("f4_digits", {16'd0, digits}, 32'h6789);
    chk("f4_seg_err", {31'd0, seg_err}, 32'd0);
    chk("f34_count", n_valid - v0, 2);

    // Two digits enabled at once: one an_err pulse at edge 7, nothing captured.
    v0 = n_valid;
    a0 = n_anerr;
    an = 4'b1100; a_to_g = glyph[5];
    repeat (7) @(negedge clk);
    chk("an_err_edge6", {31'd0, an_err}, 32'd0);
    @(negedge clk);
    chk("an_err_edge7", {31'd0, an_err}, 32'd1);
    @(negedge clk);
    chk("an_err_edge8", {31'd0, an_err}, 32'd0);
    repeat (1) @(negedge clk);
    hold(4'b1111, 7'b1111111, 10);
    chk("an_err_count", n_anerr - a0, 1);
    chk("an_err_no_valid", n_valid - v0, 0);
    chk("an_err_digits", {16'd0, digits}, 32'h6789);

    // Timeout: last capture at edge 7 of digit 1, stale rises at edge 107.
    v0 = n_valid;
    dig(0, 1, 20);
    an = 4'b1101; a_to_g = glyph[2];
    repeat (20) @(negedge clk);
    an = 4'b1111; a_to_g = 7'b1111111;
    repeat (87) @(negedge clk);
    chk("stale_edge106", {31'd0, stale}, 32'd0);
    @(negedge clk);
    chk("stale_edge107", {31'd0, stale}, 32'd1);
    chk("stale_digits_kept", {16'd0, digits}, 32'h6789);
    chk("stale_seg_err_kept", {31'd0, seg_err}, 32'd0);
    hold(4'b1111, 7'b1111111, 20);
    dig(2, 3, 20); dig(3, 4, 20);
    hold(4'b1111, 7'b1111111, 5);
    chk("stale_seen_cleared", n_valid - v0, 0);
    dig(0, 5, 20); dig(1, 6, 20);
    hold(4'b1111, 7'b1111111, 5);
    chk("stale_recover_count", n_valid - v0, 1);
    chk("stale_recover_digits", {16'd0, digits}, 32'h4365);
    chk("stale_recover_stale", {31'd0, stale}, 32'd0);

    // Reset mid-frame discards the partial frame.
    dig(0, 1, 20); dig(1, 2, 20); dig(2, 3, 20);
    v0 = n_valid;
    clr = 1'b0; an = 4'b1111; a_to_g = 7'b1111111;
    @(negedge clk);
    chk("clr_digits", {16'd0, digits}, 32'd0);
    chk("clr_valid", {31'd0, valid}, 32'd0);
    chk("clr_seg_err", {31'd0, seg_err}, 32'd0);
    chk("clr_an_err", {31'd0, an_err}, 32'd0);
    chk("clr_stale", {31'd0, stale}, 32'd1);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    dig(3, 4, 20);
    hold(4'b1111, 7'b1111111, 10);
    chk("clr_no_valid", n_valid - v0, 0);
    chk("clr_after_digits", {16'd0, digits}, 32'd0);
    chk("clr_after_stale", {31'd0, stale}, 32'd1);

    // Randomized frames against the model.
    do_reset();
    model_clear();
    m_frames = 0;
    m_anerr  = 0;
    v0       = n_valid;
    a0       = n_anerr;
    model_on = 1'b1;
    for (int f = 0; f < 40; f++) begin
      ra = 4'b1111;
      ra[$urandom_range(0, 3)] = 1'b0;
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom);
      else rs = glyph[$urandom_range(0, 15)];
      rand_window(ra, rs, $urandom_range(6, 15));
      if ($urandom_range(0, 2) == 0)
        rand_window(ra, rs ^ 7'($urandom_range(1, 127)), $urandom_range(1, 3));
      rand_window(4'b1111, 7'b1111111, $urandom_range(1, 8));
      if ($urandom_range(0, 5) == 0) begin
        do rm = 4'($urandom); while ($countones(rm) > 2);
        rand_window(rm, glyph[$urandom_range(0, 15)], $urandom_range(6, 10));
        rand_window(4'b1111, 7'b1111111, $urandom_range(1, 8));
      end
    end
    for (int k = 0; k < 4; k++) begin
      ra = 4'b1111;
      ra[k] = 1'b0;
      rand_window(ra, glyph[$urandom_range(0, 15)], 12);
      rand_window(4'b1111, 7'b1111111, 3);
    end
    hold(4'b1111, 7'b1111111, 20);
    model_on = 1'b0;
    chk("rand_queue_drained", exp_q.size(), 0);
    chk("rand_frame_count", n_valid - v0, m_frames);
    chk("rand_an_err_count", n_anerr - a0, m_anerr);
    chk("rand_stale", {31'd0, stale}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side monitor for the multiplexed four-digit seven-segment bus driven by the display driver. It samples the active-low digit enables and segment lines, waits for each digit's dwell to settle, decodes the glyph back to a hex nibble, and publishes a complete 16-bit value once all four digits have been seen. It sits beside the display driver on the same `clk`, for on-board loopback checking of the counter/display path and for self-test of the display wiring.

## Interface
- `SETTLE`, default 4: consecutive stable cycles required before a digit is sampled (1..255).
- `TIMEOUT`, default 1048576: cycles without any capture before the frame is declared stale.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-low.
- `an`, input, 4: digit enables, active-low, expected one-hot-low; `an[0]` low selects digit 0 (least significant).
- `a_to_g`, input, 7: segments, active-low; bit 6 is segment a, bit 0 is segment g.
- `digits`, output, 16: last complete frame; digit k is in `digits[4k+3:4k]`.
- `valid`, output, 1: one-cycle pulse when `digits` updates.
- `seg_err`, output, 1: sticky per frame; the published frame contained an undecodable glyph.
- `an_err`, output, 1: one-cycle pulse when a settled `an` had more than one bit low.
- `stale`, output, 1: high when no capture has occurred for `TIMEOUT` cycles, and after reset.

## Operation
- `an` and `a_to_g` each pass through a 2-flop synchronizer. Only the synchronized values are used.
- Stability counter `stab` counts 0..`SETTLE` and saturates at `SETTLE`.
  - It resets to 0 on any cycle where the synchronized {an, a_to_g} differs from its value one cycle earlier.
  - Otherwise it increments.
- A settle event occurs on the cycle `stab` reaches `SETTLE`. There is exactly one settle event per stable window.
- At a settle event, the action depends on the synchronized `an`:
  - `4'b1111`: blank period; ignore.
  - Exactly one bit low: capture the glyph into slot k, set `seen[k]`, and OR the glyph's error flag into `err_acc`. A second window on the same digit overwrites slot k (last wins).
  - Two or more bits low: pulse `an_err`. Nothing is captured.
- Glyph decode, a..g, 0 = lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern decodes to nibble 0 and sets the glyph's error flag.
- Publish happens on the cycle after a capture that leaves `seen == 4'b1111`:
  - `digits` is loaded from the slots.
  - `seg_err` is loaded from `err_acc`.
  - `valid` pulses and `stale` clears.
  - `seen` and `err_acc` clear.
- Timeout counter:
  - Clears on every capture and counts otherwise.
  - On reaching `TIMEOUT`, it sets `stale`, clears `seen` and `err_acc`, and holds.
  - `digits` and `seg_err` retain their last published values.

## Timing
- Reset (async assert): `digits`=0, `valid`=0, `seg_err`=0, `an_err`=0, `stale`=1. `seen`, `err_acc`, slots, `stab` and timeout counter are all cleared.
- Synchronizer outputs after reset are 4'b1111 / 7'b1111111, so reset itself produces no capture.
- Latency: with inputs changed before edge 0 and then held, the settle event and slot capture occur at edge `SETTLE`+3. `an_err` also pulses at edge `SETTLE`+3.
- The `valid` pulse follows at edge `SETTLE`+4 of the completing digit.
- `valid` is never high on two consecutive cycles.
- Capture and timeout expiry in the same cycle: the capture wins. The counter clears and `stale` is not set.
- Reset asserted mid-frame: the partial frame is discarded and no `valid` is issued.
- Glitches shorter than `SETTLE` cycles are never sampled.

## Test plan
- Drive the four digits 3,7,A,0 (an 1110/1101/1011/0111), each held 20 cycles with `SETTLE`=4 -> one `valid` pulse, `digits`=16'h0A73, `seg_err`=0, `stale`=0.
- Hold digit 0 at glyph 1001111 for exactly 6 cycles from edge 0 -> slot 0 captured at edge 7. A 3-cycle segment glitch inside a window restarts `stab` and produces no extra capture.
- Send a frame whose digit 2 is glyph 1111110 -> `digits[11:8]`=0, `seg_err`=1. A following clean frame gives `seg_err`=0.
- Hold `an`=1100 stable for 10 cycles -> single `an_err` pulse at edge 7, no slot change, no `valid`.
- With `TIMEOUT`=100, capture digits 0 and 1 then hold `an`=1111 for 100+ cycles -> `stale`=1, `digits` unchanged. Then four new digits -> `valid` pulse.
- Assert `clr` low after 3 of 4 digits, release, and send digit 3 only -> no `valid`. All outputs read reset values during and after `clr`.
